// File: rtl/ad7864_conv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ad7864_conv_sequencer
// Purpose  : Paces AD7864 conversions (CONVST/BUSY handshake), then fires the
//            downstream serializer enable. Optional macro: OVERRUN_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ad7864_conv_sequencer #(
    parameter int SAMPLE_DIV   = 1500,
    parameter int CONVST_LOW   = 3,
    parameter int BUSY_TIMEOUT = 255,
    parameter int ENABLE_W     = 2,
    parameter int XFER_CYCLES  = 200
) (
    input  logic        clkin,
    input  logic        rst_bar,
    input  logic        run,
    input  logic        busy,
    output logic        convst_bar,
    output logic        enable,
    output logic [15:0] frame_cnt,
    output logic        overrun,
    output logic        timeout_err,
    output logic [7:0]  overrun_cnt
);

    localparam int c_div_w   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_max_a   = (CONVST_LOW > BUSY_TIMEOUT) ? CONVST_LOW : BUSY_TIMEOUT;
    localparam int c_max_b   = (ENABLE_W > XFER_CYCLES) ? ENABLE_W : XFER_CYCLES;
    localparam int c_tmr_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(SAMPLE_DIV - 1);
    localparam logic [c_tmr_w-1:0] c_conv_load = c_tmr_w'(CONVST_LOW - 1);
    localparam logic [c_tmr_w-1:0] c_busy_load = c_tmr_w'(BUSY_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_en_load   = c_tmr_w'(ENABLE_W - 1);
    localparam logic [c_tmr_w-1:0] c_xfer_load = c_tmr_w'(XFER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONV      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_WAIT_FALL = 3'd3,
        S_EN        = 3'd4,
        S_XFER      = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_tmr_w-1:0]   r_timer;
    logic [c_div_w-1:0]   r_div;
    logic [2:0]           r_busy_sync;
    logic                 w_tick;
    logic                 w_drop;
    logic                 w_busy_rise;
    logic                 w_busy_fall;

    // [0],[1] form the synchronizer; [2] is the previous synchronized value.
    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            r_busy_sync <= 3'b000;
        end else begin
            r_busy_sync <= {r_busy_sync[1:0], busy};
        end
    end

    assign w_busy_rise = r_busy_sync[1] & ~r_busy_sync[2];
    assign w_busy_fall = ~r_busy_sync[1] & r_busy_sync[2];

    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            r_div <= '0;
        end else if (!run || (r_div == c_div_last)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick = run && (r_div == c_div_last);
    assign w_drop = w_tick && (r_state != S_IDLE);

    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            convst_bar  <= 1'b1;
            enable      <= 1'b0;
            frame_cnt   <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state    <= S_CONV;
                        convst_bar <= 1'b0;
                        r_timer    <= c_conv_load;
                    end
                end
                S_CONV: begin
                    if (r_timer == '0) begin
                        r_state    <= S_WAIT_RISE;
                        convst_bar <= 1'b1;
                        r_timer    <= c_busy_load;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_WAIT_RISE: begin
                    if (w_busy_rise) begin
                        r_state <= S_WAIT_FALL;
                        r_timer <= c_busy_load;
                    end else if (r_timer == '0) begin
                        r_state     <= S_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_WAIT_FALL: begin
                    if (w_busy_fall) begin
                        r_state <= S_EN;
                        enable  <= 1'b1;
                        r_timer <= c_en_load;
                    end else if (r_timer == '0) begin
                        r_state     <= S_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_EN: begin
                    if (r_timer == '0) begin
                        r_state <= S_XFER;
                        enable  <= 1'b0;
                        r_timer <= c_xfer_load;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_XFER: begin
                    if (r_timer == '0) begin
                        r_state   <= S_IDLE;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    convst_bar <= 1'b1;
                    enable     <= 1'b0;
                end
            endcase
        end
    end

    // A tick while busy with a frame is dropped, never queued.
    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            overrun <= 1'b0;
        end else if (w_drop) begin
            overrun <= 1'b1;
        end
    end

`ifdef OVERRUN_COUNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            r_ovr_cnt <= 8'h00;
        end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign overrun_cnt = r_ovr_cnt;
`else
    assign overrun_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/ad7864_conv_sequencer.md
AD7864_CONV_SEQUENCER -- requirements
Module: ad7864_conv_sequencer

Interface
REQ-001 Parameter SAMPLE_DIV, default 1500, sets clkin cycles per sample period (24 MHz / 1500 = 16 kHz).
REQ-002 Parameter CONVST_LOW, default 3, sets clkin cycles convst_bar is held low.
REQ-003 Parameter BUSY_TIMEOUT, default 255, sets the maximum clkin cycles to wait for each busy edge.
REQ-004 Parameter ENABLE_W, default 2, sets the width of the enable pulse in clkin cycles.
REQ-005 Parameter XFER_CYCLES, default 200, sets the guard window in clkin cycles reserved for the 4-channel read/serialize chain.
REQ-006 The clock SHALL be clkin (input, 1 bit): single 24 MHz clock, rising edge only.
REQ-007 The reset SHALL be rst_bar (input, 1 bit): asynchronous, active-low.
REQ-008 run (input, 1 bit) SHALL be a level: 1 means sample periodically, 0 means stop after the current frame.
REQ-009 busy (input, 1 bit) SHALL be the AD7864 BUSY pin, asynchronous, high during conversion.
REQ-010 convst_bar (output, 1 bit) SHALL drive the AD7864 CONVST pin, active-low.
REQ-011 enable (output, 1 bit) SHALL be the start pulse to the downstream parallel-to-serial stage.
REQ-012 frame_cnt (output, 16 bits) SHALL count completed frames.
REQ-013 overrun (output, 1 bit) SHALL be a sticky flag: a sample tick occurred while the sequencer was not IDLE.
REQ-014 timeout_err (output, 1 bit) SHALL be a sticky flag: a busy edge was not seen within BUSY_TIMEOUT.
REQ-015 overrun_cnt (output, 8 bits) SHALL be the overrun event count (see Configuration).

Function
REQ-016 busy SHALL pass through a 2-flop synchronizer before use; edge detection SHALL use the synchronized value only.
REQ-017 A free-running tick counter SHALL count 0..SAMPLE_DIV-1 and wrap, asserting an internal tick for 1 cycle at wrap; it SHALL run only while run=1 and SHALL be cleared to 0 while run=0.
REQ-018 FSM states SHALL be IDLE, CONV, WAIT_RISE, WAIT_FALL, EN, XFER.
REQ-019 IDLE -> CONV on tick with run=1; convst_bar SHALL go low on the first CONV cycle.
REQ-020 CONV SHALL hold convst_bar low exactly CONVST_LOW cycles, then release it high and go to WAIT_RISE.
REQ-021 WAIT_RISE -> WAIT_FALL on synchronized busy rising edge.
REQ-022 WAIT_FALL -> EN on synchronized busy falling edge.
REQ-023 In WAIT_RISE or WAIT_FALL, if BUSY_TIMEOUT cycles elapse without the edge, the FSM SHALL set timeout_err and return to IDLE without asserting enable.
REQ-024 EN SHALL drive enable=1 for exactly ENABLE_W cycles, then go to XFER.
REQ-025 XFER SHALL wait XFER_CYCLES cycles, then increment frame_cnt (wrapping 0xFFFF->0) and return to IDLE.
REQ-026 A tick in any state other than IDLE SHALL set overrun and be dropped; it SHALL NOT queue a conversion.
REQ-027 run=0 mid-frame SHALL NOT abort the frame; the frame completes normally and no new CONV starts.
REQ-028 A tick and the XFER->IDLE transition in the same cycle SHALL count as overrun; the conversion starts on the next tick.
REQ-029 The timeout counter SHALL reload on every state entry.
REQ-030 Outputs SHALL be registered; enable and convst_bar SHALL be glitch-free.

Reset
REQ-031 While rst_bar=0: state=IDLE, convst_bar=1, enable=0, frame_cnt=0, overrun=0, timeout_err=0, overrun_cnt=0, all counters and synchronizer flops 0.
REQ-032 Reset asserted mid-CONV SHALL immediately return convst_bar high; on release the first conversion SHALL wait for a full SAMPLE_DIV period.
REQ-033 Sticky flags SHALL clear only on reset.

Configuration
REQ-034 Macro OVERRUN_COUNT_EN defined: overrun_cnt SHALL increment on each dropped tick and saturate at 0xFF.
REQ-035 Macro OVERRUN_COUNT_EN undefined: overrun_cnt SHALL be constant 0 with no counter logic; the overrun flag is unaffected.

Verification
REQ-036 run=1, busy high 2 cycles after convst_bar rises and low 40 cycles later -> convst_bar low 3 cycles, enable high 2 cycles starting 3-4 cycles after busy falls, frame_cnt=1 after XFER.
REQ-037 busy held 0 -> timeout_err=1 after 255 cycles in WAIT_RISE, enable never asserted, next tick starts a new CONV.
REQ-038 SAMPLE_DIV=150, busy low 300 cycles -> overrun=1; overrun_cnt=1 with OVERRUN_COUNT_EN defined, 0 without.
REQ-039 run dropped during WAIT_FALL -> frame completes, frame_cnt increments once, no further convst_bar pulses.
REQ-040 rst_bar pulsed low during CONV -> convst_bar high asynchronously, all outputs at reset values, first new convst_bar 1500 cycles after release.
